// File: rtl/seq_sub_pkg.sv
// seq_sub_pkg: shared types and sizing helpers for the nibble-serial subtractor
package seq_sub_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam int NIB = 4;

    function automatic int cnt_width(input int width);
        return ($clog2(width / NIB) < 1) ? 1 : $clog2(width / NIB);
    endfunction

    localparam int CNT_W = cnt_width(16);

endpackage

// File: rtl/seq_sub_16_bit_cla.sv
// cla_4_bit_slice: combinational 4-bit carry-lookahead adder slice
module cla_4_bit_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = x & y;
    assign p = x ^ y;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ c;

endmodule

// File: rtl/seq_sub_16_bit.sv
// seq_sub_16_bit: multi-cycle a - b - bin, one nibble per clock via a + ~b + ~bin
module seq_sub_16_bit
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NN = WIDTH / NIB;
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [NIB-1:0]   s;
    logic             co;
    logic             last;

    cla_4_bit_slice u_slice (
        .x  (op_a[cnt*NIB +: NIB]),
        .y  (op_b[cnt*NIB +: NIB]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    assign last = (cnt == CW'(NN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_a  <= a;
                    op_b  <= ~b;
                    carry <= ~bin;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    diff[cnt*NIB +: NIB] <= s;
                    carry <= co;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        // op_b holds ~b, so a and b differ in sign when op_a and op_b MSBs match
                        bout  <= ~co;
                        ovf   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (s[NIB-1] != op_a[WIDTH-1]);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
